// File: rtl/native_bus_arbiter.sv
// native_bus_arbiter: shares one native memory port between the instruction
// fetch read port and the data read/write port of the core.
// Reads are arbitrated with at most one read outstanding; the data master's
// write channel is passed straight through to the memory.
// Build option: define ARB_ROUND_ROBIN_EN to break simultaneous read requests
// by alternating masters; otherwise the data master always wins a tie.
module native_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction master read
  input  logic                  i_r_addr_valid,
  input  logic [ADDR_WIDTH-1:0] i_r_addr,
  output logic                  i_r_addr_ready,
  output logic                  i_r_data_valid,
  output logic [DATA_WIDTH-1:0] i_r_data,
  input  logic                  i_r_data_ready,
  // data master read
  input  logic                  d_r_addr_valid,
  input  logic [ADDR_WIDTH-1:0] d_r_addr,
  output logic                  d_r_addr_ready,
  output logic                  d_r_data_valid,
  output logic [DATA_WIDTH-1:0] d_r_data,
  input  logic                  d_r_data_ready,
  // data master write
  input  logic                  d_w_data_addr_valid,
  input  logic [DATA_WIDTH-1:0] d_w_data,
  input  logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic                  d_w_data_addr_ready,
  output logic                  d_w_resp_valid,
  output logic [RESP_WIDTH-1:0] d_w_resp,
  input  logic                  d_w_resp_ready,
  // memory read
  output logic                  m_r_addr_valid,
  output logic [ADDR_WIDTH-1:0] m_r_addr,
  input  logic                  m_r_addr_ready,
  input  logic                  m_r_data_valid,
  input  logic [DATA_WIDTH-1:0] m_r_data,
  output logic                  m_r_data_ready,
  // memory write
  output logic                  m_w_data_addr_valid,
  output logic [DATA_WIDTH-1:0] m_w_data,
  output logic [ADDR_WIDTH-1:0] m_w_addr,
  input  logic                  m_w_data_addr_ready,
  input  logic                  m_w_resp_valid,
  input  logic [RESP_WIDTH-1:0] m_w_resp,
  output logic                  m_w_resp_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic OWNER_D = 1'b0;
  localparam logic OWNER_I = 1'b1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  owner_q, owner_d;
  logic                  last_q,  last_d;

  logic tie_to_i;
  logic gnt_i;
  logic gnt_d;

  // Tie-break and grant selection among pending read requests.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    // Favour whichever master was not served last.
    tie_to_i = (last_q == OWNER_D);
`else
    tie_to_i = 1'b0;
`endif
    gnt_i = i_r_addr_valid & (~d_r_addr_valid | tie_to_i);
    gnt_d = d_r_addr_valid & (~i_r_addr_valid | ~tie_to_i);
  end

  // Read FSM: next state, datapath capture and handshake outputs.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    owner_d        = owner_q;
    last_d         = last_q;
    i_r_addr_ready = 1'b0;
    d_r_addr_ready = 1'b0;
    m_r_addr_valid = 1'b0;
    m_r_data_ready = 1'b0;
    i_r_data_valid = 1'b0;
    d_r_data_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        i_r_addr_ready = gnt_i;
        d_r_addr_ready = gnt_d;
        // A grant implies the matching valid, so a grant is a handshake.
        if (gnt_i) begin
          addr_d  = i_r_addr;
          owner_d = OWNER_I;
          last_d  = OWNER_I;
          state_d = ST_ADDR;
        end else if (gnt_d) begin
          addr_d  = d_r_addr;
          owner_d = OWNER_D;
          last_d  = OWNER_D;
          state_d = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        m_r_addr_valid = 1'b1;
        if (m_r_addr_ready) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        m_r_data_ready = 1'b1;
        if (m_r_data_valid) begin
          data_d  = m_r_data;
          state_d = ST_RESP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RESP: begin
        // Only the owner sees the returned word; data_q holds while stalled.
        if (owner_q == OWNER_I) begin
          i_r_data_valid = 1'b1;
          if (i_r_data_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          d_r_data_valid = 1'b1;
          if (d_r_data_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      owner_q <= OWNER_D;
      last_q  <= OWNER_D;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign m_r_addr = addr_q;
  assign i_r_data = data_q;
  assign d_r_data = data_q;

  // Write channel belongs to the data master and bypasses the read FSM.
  assign m_w_data_addr_valid = d_w_data_addr_valid;
  assign m_w_data            = d_w_data;
  assign m_w_addr            = d_w_addr;
  assign d_w_data_addr_ready = m_w_data_addr_ready;
  assign d_w_resp_valid      = m_w_resp_valid;
  assign d_w_resp            = m_w_resp;
  assign m_w_resp_ready      = d_w_resp_ready;

endmodule

// File: tb/tb_native_bus_arbiter.sv
// Scoreboard bench for native_bus_arbiter with a two-stage memory model.
module tb_native_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_r_addr_valid, i_r_addr_ready, i_r_data_valid, i_r_data_ready;
  logic [AW-1:0] i_r_addr;
  logic [DW-1:0] i_r_data;
  logic          d_r_addr_valid, d_r_addr_ready, d_r_data_valid, d_r_data_ready;
  logic [AW-1:0] d_r_addr;
  logic [DW-1:0] d_r_data;
  logic          d_w_data_addr_valid, d_w_data_addr_ready, d_w_resp_valid, d_w_resp_ready;
  logic [DW-1:0] d_w_data;
  logic [AW-1:0] d_w_addr;
  logic [RW-1:0] d_w_resp;
  logic          m_r_addr_valid, m_r_addr_ready, m_r_data_valid, m_r_data_ready;
  logic [AW-1:0] m_r_addr;
  logic [DW-1:0] m_r_data;
  logic          m_w_data_addr_valid, m_w_data_addr_ready, m_w_resp_valid, m_w_resp_ready;
  logic [DW-1:0] m_w_data;
  logic [AW-1:0] m_w_addr;
  logic [RW-1:0] m_w_resp;

  always #5 clk = ~clk;

  native_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) dut (
    .clk(clk), .rst(rst),
    .i_r_addr_valid(i_r_addr_valid), .i_r_addr(i_r_addr), .i_r_addr_ready(i_r_addr_ready),
    .i_r_data_valid(i_r_data_valid), .i_r_data(i_r_data), .i_r_data_ready(i_r_data_ready),
    .d_r_addr_valid(d_r_addr_valid), .d_r_addr(d_r_addr), .d_r_addr_ready(d_r_addr_ready),
    .d_r_data_valid(d_r_data_valid), .d_r_data(d_r_data), .d_r_data_ready(d_r_data_ready),
    .d_w_data_addr_valid(d_w_data_addr_valid), .d_w_data(d_w_data), .d_w_addr(d_w_addr),
    .d_w_data_addr_ready(d_w_data_addr_ready),
    .d_w_resp_valid(d_w_resp_valid), .d_w_resp(d_w_resp), .d_w_resp_ready(d_w_resp_ready),
    .m_r_addr_valid(m_r_addr_valid), .m_r_addr(m_r_addr), .m_r_addr_ready(m_r_addr_ready),
    .m_r_data_valid(m_r_data_valid), .m_r_data(m_r_data), .m_r_data_ready(m_r_data_ready),
    .m_w_data_addr_valid(m_w_data_addr_valid), .m_w_data(m_w_data), .m_w_addr(m_w_addr),
    .m_w_data_addr_ready(m_w_data_addr_ready),
    .m_w_resp_valid(m_w_resp_valid), .m_w_resp(m_w_resp), .m_w_resp_ready(m_w_resp_ready)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:63];
  logic        s1_v, rd_v;
  logic [31:0] s1_a, rd_d;

  function automatic logic [31:0] pat(input int k);
    return 32'hA500_0000 + k;
  endfunction

  assign m_r_addr_ready      = 1'b1;
  assign m_r_data_valid      = rd_v;
  assign m_r_data            = rd_d;
  assign m_w_data_addr_ready = 1'b1;
  assign m_w_resp            = 2'b00;

  // Memory array and write response; reset reloads the known pattern.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 64; k++) mem[k] <= pat(k);
      mem[4] <= 32'h0000_0013;
      m_w_resp_valid <= 1'b0;
    end else begin
      if (m_w_data_addr_valid && m_w_data_addr_ready) begin
        mem[m_w_addr[7:2]] <= m_w_data;
        m_w_resp_valid <= 1'b1;
      end else if (m_w_resp_valid && m_w_resp_ready) begin
        m_w_resp_valid <= 1'b0;
      end
    end
  end

  // Read path: address taken, then data registered one cycle later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0; s1_a <= 32'h0; rd_v <= 1'b0; rd_d <= 32'h0;
    end else begin
      if (m_r_addr_valid && m_r_addr_ready) begin
        s1_v <= 1'b1; s1_a <= m_r_addr;
      end else begin
        s1_v <= 1'b0;
      end
      if (s1_v) begin
        rd_v <= 1'b1; rd_d <= mem[s1_a[7:2]];
      end else if (rd_v && m_r_data_ready) begin
        rd_v <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct { logic is_i; logic [31:0] data; } exp_t;
  exp_t sb_q[$];

  task automatic push_exp(input logic is_i, input logic [31:0] d);
    exp_t e;
    e.is_i = is_i; e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic is_i, input logic [31:0] d);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_unexpected: got master_i=%0d data %h expected no delivery", is_i, d);
    end else begin
      e = sb_q.pop_front();
      check("sb_master_i", {31'b0, is_i}, {31'b0, e.is_i});
      check("sb_data", d, e.data);
    end
  endtask

  // Monitor: every read-data handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_r_data_valid && d_r_data_valid) begin
        n_vec++; n_err++;
        $display("FAIL both_valid: got both data_valid=1 expected at most one");
      end
      if (i_r_data_valid && i_r_data_ready) sb_pop(1'b1, i_r_data);
      if (d_r_data_valid && d_r_data_ready) sb_pop(1'b0, d_r_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic is_i, input logic [31:0] a, input int budget);
    logic ok;
    ok = 1'b0;
    if (is_i) begin i_r_addr = a; i_r_addr_valid = 1'b1; end
    else      begin d_r_addr = a; d_r_addr_valid = 1'b1; end
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (is_i ? i_r_addr_ready : d_r_addr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin @(posedge clk); #1; end
    if (is_i) i_r_addr_valid = 1'b0;
    else      d_r_addr_valid = 1'b0;
    check(is_i ? "i_grant_seen" : "d_grant_seen", {31'b0, ok}, 32'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 400; c++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", sb_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic seen;
    i_r_addr_valid = 1'b0; i_r_addr = 32'h0; i_r_data_ready = 1'b1;
    d_r_addr_valid = 1'b0; d_r_addr = 32'h0; d_r_data_ready = 1'b1;
    d_w_data_addr_valid = 1'b0; d_w_data = 32'h0; d_w_addr = 32'h0; d_w_resp_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_i_addr_ready", {31'b0, i_r_addr_ready}, 32'd0);
    check("rst_d_addr_ready", {31'b0, d_r_addr_ready}, 32'd0);
    check("rst_i_data_valid", {31'b0, i_r_data_valid}, 32'd0);
    check("rst_d_data_valid", {31'b0, d_r_data_valid}, 32'd0);
    check("rst_m_addr_valid", {31'b0, m_r_addr_valid}, 32'd0);
    check("rst_m_data_ready", {31'b0, m_r_data_ready}, 32'd0);
    check("rst_m_addr", m_r_addr, 32'd0);
    check("rst_i_data", i_r_data, 32'd0);
    check("rst_w_resp_ready", {31'b0, m_w_resp_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Tie from reset: round robin serves instruction first, else data first.
`ifdef ARB_ROUND_ROBIN_EN
    push_exp(1'b1, pat(0)); push_exp(1'b0, pat(1));
`else
    push_exp(1'b0, pat(1)); push_exp(1'b1, pat(0));
`endif
    fork
      drive(1'b1, 32'h0, 100);
      drive(1'b0, 32'h4, 100);
    join
    drain();

    // Single fetch with latency profile.
    push_exp(1'b1, 32'h0000_0013);
    drive(1'b1, 32'h10, 50);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("fetch_i_valid", {31'b0, i_r_data_valid}, (k == 4) ? 32'd1 : 32'd0);
      check("fetch_d_valid", {31'b0, d_r_data_valid}, 32'd0);
    end
    check("fetch_i_data", i_r_data, 32'h0000_0013);
    drain();

    // Back-pressure on data master with instruction request waiting.
    d_r_data_ready = 1'b0;
    push_exp(1'b0, pat(2)); push_exp(1'b1, pat(3));
    drive(1'b0, 32'h8, 50);
    i_r_addr = 32'hC; i_r_addr_valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_r_data_valid) begin seen = 1'b1; break; end
    end
    check("bp_valid_seen", {31'b0, seen}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_d_valid", {31'b0, d_r_data_valid}, 32'd1);
      check("bp_d_data", d_r_data, pat(2));
      check("bp_i_ready", {31'b0, i_r_addr_ready}, 32'd0);
    end
    @(posedge clk); #1;
    d_r_data_ready = 1'b1;
    drive(1'b1, 32'hC, 50);
    drain();

    // Write passthrough then read-back.
    d_w_addr = 32'h20; d_w_data = 32'hDEAD_BEEF; d_w_data_addr_valid = 1'b1;
    #1;
    check("wr_m_addr", m_w_addr, 32'h20);
    check("wr_m_data", m_w_data, 32'hDEAD_BEEF);
    check("wr_m_valid", {31'b0, m_w_data_addr_valid}, 32'd1);
    check("wr_d_ready", {31'b0, d_w_data_addr_ready}, 32'd1);
    @(posedge clk); #1;
    d_w_data_addr_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (d_w_resp_valid) begin seen = 1'b1; break; end
    end
    check("wr_resp_seen", {31'b0, seen}, 32'd1);
    check("wr_resp_ok", {30'b0, d_w_resp}, 32'd0);
    @(posedge clk); #1;
    push_exp(1'b0, 32'hDEAD_BEEF);
    drive(1'b0, 32'h20, 50);
    drain();

    // Reset while the FSM waits for memory data.
    drive(1'b1, 32'h10, 50);
    @(negedge clk);
    @(negedge clk);
    check("rd_in_data", {31'b0, m_r_data_ready}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_m_ready", {31'b0, m_r_data_ready}, 32'd0);
    check("rst_mid_i_valid", {31'b0, i_r_data_valid}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_no_i_valid", {31'b0, i_r_data_valid}, 32'd0);
      check("rst_no_d_valid", {31'b0, d_r_data_valid}, 32'd0);
    end
    @(posedge clk); #1;
    push_exp(1'b1, 32'h0000_0013);
    drive(1'b1, 32'h10, 50);
    drain();

    // Fairness: both masters request continuously for 20 reads.
    apply_reset();
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 10; k++) begin
      push_exp(1'b1, pat(16 + k));
      push_exp(1'b0, pat(32 + k));
    end
`else
    for (int k = 0; k < 10; k++) push_exp(1'b0, pat(32 + k));
    for (int k = 0; k < 10; k++) push_exp(1'b1, pat(16 + k));
`endif
    fork
      begin
        for (int k = 0; k < 10; k++) drive(1'b1, 32'h40 + 32'(4 * k), 300);
      end
      begin
        for (int j = 0; j < 10; j++) drive(1'b0, 32'h80 + 32'(4 * j), 300);
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/native_bus_arbiter.md
# native_bus_arbiter

Merges the core's instruction-fetch read port and data read/write port onto the single native bus port of one shared memory, so one `native_memory` instance serves both. Sits between the core bus interface and the memory. Read traffic is arbitrated, with at most one read outstanding. The write channel belongs to the data master only and passes straight through.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: address width, `BUS_WIDTH`.
- `DATA_WIDTH`, default 32: data width, `BUS_WIDTH`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `i_r_addr_valid`, `i_r_addr` in 1/32; `i_r_addr_ready` out 1: instruction master read address.
- `i_r_data_valid`, `i_r_data` out 1/32; `i_r_data_ready` in 1: instruction master read data.
- `d_r_addr_valid`, `d_r_addr` in 1/32; `d_r_addr_ready` out 1: data master read address.
- `d_r_data_valid`, `d_r_data` out 1/32; `d_r_data_ready` in 1: data master read data.
- `d_w_data_addr_valid`, `d_w_data`, `d_w_addr` in 1/32/32; `d_w_data_addr_ready` out 1: data master write.
- `d_w_resp_valid`, `d_w_resp` out 1/`BUS_RESP_WIDTH`; `d_w_resp_ready` in 1: data master write response.
- `m_r_addr_valid`, `m_r_addr` out; `m_r_addr_ready` in: memory read address.
- `m_r_data_valid`, `m_r_data` in; `m_r_data_ready` out: memory read data.
- `m_w_*`: memory write channel, mirroring the `d_w_*` ports.

## Operation
Read FSM states:
- IDLE
  - `i_r_addr_ready` and `d_r_addr_ready` are driven combinationally. Only the granted master sees 1.
  - Grant goes to the sole requester. On a tie, the tie rule in Configuration applies.
  - On a handshake, latch the address into `addr_q` and the owner into `owner_q`, update `last_q`, and go to ADDR.
- ADDR
  - `m_r_addr_valid`=1 and `m_r_addr`=`addr_q`.
  - On `m_r_addr_ready`, go to DATA.
- DATA
  - `m_r_data_ready`=1.
  - On `m_r_data_valid`, latch `m_r_data` into `data_q` and go to RESP.
- RESP
  - The owner's `*_r_data_valid`=1 with `data_q`; the other master sees 0.
  - On the owner's `*_r_data_ready`, go to IDLE.

Rules:
- Both `*_r_addr_ready` are 0 outside IDLE. New requests wait, and their valid must stay held.
- `m_r_data_valid` is ignored outside DATA.
- Write channel: combinational passthrough of `d_w_*` to and from `m_w_*`, independent of the read FSM. The instruction master has no write port.

## Timing
Reset values:
- All outputs 0.
- State IDLE, `addr_q`/`data_q` = 0.
- `owner_q` = data, `last_q` = data.
- Write passthrough outputs follow their inputs.

Latency:
- Master address handshake at edge N.
- `m_r_addr_valid` during cycle N..N+1.
- With a ready memory: memory registers the data at N+2, captured at N+3.
- Master `*_r_data_valid` from N+3.
- Minimum 4 cycles between successive accepted reads.

Boundary conditions:
- A simultaneous request from both masters in IDLE grants exactly one; the loser is served next.
- A master deasserting `*_r_data_ready` stalls RESP indefinitely; `data_q` is held stable.
- `rst` mid-transaction returns to IDLE immediately. The in-flight read is discarded and no data is delivered to any master.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on a tie, grant the master not in `last_q`. With reset `last_q`=data, the first tie goes to instruction.
- `ARB_ROUND_ROBIN_EN` undefined: the data master always wins ties. `last_q` is still maintained but unused for grant.

## Test plan
- Single fetch: memory word 0x00000013 at address 0x10; `i_r_addr`=0x10 → `i_r_data`=0x00000013, valid 3 cycles after the handshake; `d_r_data_valid` stays 0.
- Tie, round robin: both request in the same cycle, I→0x0 and D→0x4 → instruction served first, data next; each gets the correct word. Without the macro, data is served first.
- Back-pressure: hold `d_r_data_ready`=0 for 5 cycles in RESP → `d_r_data` stable; `i_r_addr_ready` stays 0; completes on ready.
- Write passthrough: `d_w_addr`=0x20, `d_w_data`=0xDEADBEEF → memory response OK back on `d_w_resp`. A following read of 0x20 returns 0xDEADBEEF.
- Reset in DATA: pulse `rst` → FSM IDLE, no `*_r_data_valid`. A new fetch afterwards completes normally.
- Fairness: both masters request continuously for 20 reads → grants alternate I,D,I,D with the macro defined.
